// File: rtl/hash_msg_packer_pkg.sv
// Shared types and constants for the hash message packer and its hasher.
package hash_msg_packer_pkg;

  localparam int MAX_BYTES = 8;
  localparam int LEN_W     = 4;
  localparam int HASH_W    = 32;
  localparam int DATA_W    = 8 * MAX_BYTES;

  localparam logic [HASH_W-1:0] FNV_OFFSET = 32'h811C_9DC5;
  localparam logic [HASH_W-1:0] FNV_PRIME  = 32'h0100_0193;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_HASH,
    ST_OUT
  } state_t;

endpackage

// File: rtl/hash_msg_packer_hasher.sv
// Combinational FNV-1a style hash over the first data_len bytes, finalised by
// folding in the length so that trailing zero bytes change the result.
module hash_msg_packer_hasher
  import hash_msg_packer_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [LEN_W-1:0]  data_len,
  output logic [HASH_W-1:0] hash
);

  always_comb begin
    hash = FNV_OFFSET;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < int'(data_len)) begin
        hash = (hash ^ {{(HASH_W-8){1'b0}}, data[8*i +: 8]}) * FNV_PRIME;
      end
    end
    hash = hash ^ {{(HASH_W-LEN_W){1'b0}}, data_len};
  end

endmodule

// File: rtl/hash_msg_packer.sv
// Packs a byte stream into one 8-byte message, hashes it in a single cycle and
// holds the registered result on a valid/ready port until it is taken.
module hash_msg_packer
  import hash_msg_packer_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              flush,
  output logic [HASH_W-1:0] hash_out,
  output logic [LEN_W-1:0]  len_out,
  output logic              overflow_out,
  output logic              timeout_out,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  state_t              state;
  logic [DATA_W-1:0]   data;
  logic [LEN_W-1:0]    len;
  logic                ovf;
  logic                tmo;
  logic [CNT_W-1:0]    idle_cnt;
  logic [HASH_W-1:0]   hash_comb;
  logic                accept;

  assign in_ready = (state == ST_IDLE) || (state == ST_FILL);
  assign accept   = in_valid && in_ready;

  hash_msg_packer_hasher u_hasher (
    .data     (data),
    .data_len (len),
    .hash     (hash_comb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      data         <= '0;
      len          <= '0;
      ovf          <= 1'b0;
      tmo          <= 1'b0;
      idle_cnt     <= '0;
      hash_out     <= '0;
      len_out      <= '0;
      overflow_out <= 1'b0;
      timeout_out  <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ovf      <= 1'b0;
          tmo      <= 1'b0;
          idle_cnt <= '0;
          if (accept) begin
            data  <= {{(DATA_W-8){1'b0}}, in_byte};
            len   <= LEN_W'(1);
            state <= in_last ? ST_HASH : ST_FILL;
          end else begin
            data <= '0;
            len  <= '0;
            if (flush) state <= ST_HASH;
          end
        end
        ST_FILL: begin
          if (accept) begin
            idle_cnt <= '0;
            // Bytes past the eighth are swallowed so the sender never stalls.
            if (len < LEN_W'(MAX_BYTES)) begin
              data[{len[2:0], 3'b000} +: 8] <= in_byte;
              len <= len + LEN_W'(1);
            end else begin
              ovf <= 1'b1;
            end
            if (in_last) state <= ST_HASH;
          end else if ((IDLE_TIMEOUT != 0) && (idle_cnt == CNT_LAST)) begin
            tmo   <= 1'b1;
            state <= ST_HASH;
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        ST_HASH: begin
          hash_out     <= hash_comb;
          len_out      <= len;
          overflow_out <= ovf;
          timeout_out  <= tmo;
          out_valid    <= 1'b1;
          state        <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
